uart_comm: RTL and testbench



---
 rtl/uart_comm.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_comm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_comm.sv
// 8N1 UART transceiver with 8-entry TX/RX FIFOs and a flag/ack host handshake.
// Bit period is CLOCKRATE/BAUDRATE clocks; RX samples mid-bit after a 2-flop sync.
module uart_comm #(
   parameter int ID        = 0,
   parameter int BAUDRATE  = 115200,
   parameter int CLOCKRATE = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_flag,
   input  logic [7:0] send_data,
   input  logic       recv_flag,
   output logic [7:0] recv_data,
   output logic       send_ack,
   output logic       recv_ack,
   output logic       sendable,
   output logic       recvable,
   output logic       Tx,
   input  logic       Rx
);

   localparam int DIV  = CLOCKRATE / BAUDRATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam logic [CW-1:0] C_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);

   if (DIV < 4) begin : g_cfg_chk
      $error("uart_comm %0d: bit period must be at least 4 clocks", ID);
   end

   typedef enum logic [1:0] {
      TX_IDLE, TX_START, TX_DATA, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
   } rx_state_t;

   // ---------------- TX FIFO ----------------
   logic [7:0] r_txq [8];
   logic [2:0] r_tx_wp, r_tx_rp;
   logic [3:0] r_tx_cnt;
   logic       r_send_ack;
   logic       w_tx_push, w_tx_pop;
   logic       w_tx_full, w_tx_empty;

   assign w_tx_full  = (r_tx_cnt == 4'd8);
   assign w_tx_empty = (r_tx_cnt == 4'd0);
   assign w_tx_push  = send_flag & ~w_tx_full & ~r_send_ack;

   always_ff @(posedge clk) begin
      if (w_tx_push) r_txq[r_tx_wp] <= send_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_tx_cnt   <= '0;
         r_send_ack <= 1'b0;
      end else begin
         r_send_ack <= w_tx_push;
         if (w_tx_push) r_tx_wp <= r_tx_wp + 3'd1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 3'd1;
         unique case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + 4'd1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 4'd1;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // ---------------- TX engine ----------------
   tx_state_t     r_tx_st, w_tx_st_n;
   logic [CW-1:0] r_tx_c, w_tx_c_n;
   logic [2:0]    r_tx_bit, w_tx_bit_n;
   logic [7:0]    r_tx_sh, w_tx_sh_n;
   logic          r_tx, w_tx_n;
   logic [7:0]    w_tx_head;

   assign w_tx_head = r_txq[r_tx_rp];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_st  <= TX_IDLE;
         r_tx_c   <= '0;
         r_tx_bit <= '0;
         r_tx_sh  <= '0;
         r_tx     <= 1'b1;
      end else begin
         r_tx_st  <= w_tx_st_n;
         r_tx_c   <= w_tx_c_n;
         r_tx_bit <= w_tx_bit_n;
         r_tx_sh  <= w_tx_sh_n;
         r_tx     <= w_tx_n;
      end
   end

   // w_tx_n is the line level for the state being entered
   always_comb begin
      w_tx_st_n  = r_tx_st;
      w_tx_c_n   = r_tx_c + 1'b1;
      w_tx_bit_n = r_tx_bit;
      w_tx_sh_n  = r_tx_sh;
      w_tx_n     = 1'b1;
      w_tx_pop   = 1'b0;
      unique case (r_tx_st)
         TX_IDLE: begin
            w_tx_c_n = '0;
            if (!w_tx_empty) begin
               w_tx_pop  = 1'b1;
               w_tx_sh_n = w_tx_head;
               w_tx_st_n = TX_START;
               w_tx_n    = 1'b0;
            end
         end
         TX_START: begin
            w_tx_n = 1'b0;
            if (r_tx_c == C_END) begin
               w_tx_c_n   = '0;
               w_tx_bit_n = '0;
               w_tx_st_n  = TX_DATA;
               w_tx_n     = r_tx_sh[0];
            end
         end
         TX_DATA: begin
            w_tx_n = r_tx_sh[0];
            if (r_tx_c == C_END) begin
               w_tx_c_n = '0;
               if (r_tx_bit == 3'd7) begin
                  w_tx_st_n = TX_STOP;
                  w_tx_n    = 1'b1;
               end else begin
                  w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
                  w_tx_bit_n = r_tx_bit + 3'd1;
                  w_tx_n     = r_tx_sh[1];
               end
            end
         end
         TX_STOP: begin
            if (r_tx_c == C_END) begin
               w_tx_c_n = '0;
               // chain straight into the next frame when data is waiting
               if (!w_tx_empty) begin
                  w_tx_pop  = 1'b1;
                  w_tx_sh_n = w_tx_head;
                  w_tx_st_n = TX_START;
                  w_tx_n    = 1'b0;
               end else begin
                  w_tx_st_n = TX_IDLE;
               end
            end
         end
         default: w_tx_st_n = TX_IDLE;
      endcase
   end

   // ---------------- RX engine ----------------
   logic          r_rx_s1, r_rx_s2, r_rx_s3;
   rx_state_t     r_rx_st, w_rx_st_n;
   logic [CW-1:0] r_rx_c, w_rx_c_n;
   logic [2:0]    r_rx_bit, w_rx_bit_n;
   logic [7:0]    r_rx_sh, w_rx_sh_n;
   logic          w_rx_push;

   logic [7:0] r_rxq [8];
   logic [2:0] r_rx_wp, r_rx_rp;
   logic [3:0] r_rx_cnt;
   logic       r_recv_ack;
   logic [7:0] r_recv_data;
   logic       w_rx_pop, w_rx_full, w_rx_empty;

   assign w_rx_full  = (r_rx_cnt == 4'd8);
   assign w_rx_empty = (r_rx_cnt == 4'd0);
   assign w_rx_pop   = recv_flag & ~w_rx_empty & ~r_recv_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1  <= 1'b1;
         r_rx_s2  <= 1'b1;
         r_rx_s3  <= 1'b1;
         r_rx_st  <= RX_IDLE;
         r_rx_c   <= '0;
         r_rx_bit <= '0;
         r_rx_sh  <= '0;
      end else begin
         r_rx_s1  <= Rx;
         r_rx_s2  <= r_rx_s1;
         r_rx_s3  <= r_rx_s2;
         r_rx_st  <= w_rx_st_n;
         r_rx_c   <= w_rx_c_n;
         r_rx_bit <= w_rx_bit_n;
         r_rx_sh  <= w_rx_sh_n;
      end
   end

   always_comb begin
      w_rx_st_n  = r_rx_st;
      w_rx_c_n   = r_rx_c + 1'b1;
      w_rx_bit_n = r_rx_bit;
      w_rx_sh_n  = r_rx_sh;
      w_rx_push  = 1'b0;
      unique case (r_rx_st)
         RX_IDLE: begin
            w_rx_c_n = '0;
            if (r_rx_s3 && !r_rx_s2) w_rx_st_n = RX_START;
         end
         RX_START: begin
            if (r_rx_c == C_HALF) begin
               w_rx_c_n   = '0;
               w_rx_bit_n = '0;
               w_rx_st_n  = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_rx_c == C_END) begin
               w_rx_c_n   = '0;
               w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
               w_rx_bit_n = r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7) w_rx_st_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (r_rx_c == C_END) begin
               w_rx_c_n = '0;
               if (r_rx_s2) begin
                  w_rx_push = ~w_rx_full;
                  w_rx_st_n = RX_IDLE;
               end else begin
                  w_rx_st_n = RX_WAIT;
               end
            end
         end
         RX_WAIT: begin
            w_rx_c_n = '0;
            if (r_rx_s2) w_rx_st_n = RX_IDLE;
         end
         default: w_rx_st_n = RX_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rxq[r_rx_wp] <= r_rx_sh;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_wp     <= '0;
         r_rx_rp     <= '0;
         r_rx_cnt    <= '0;
         r_recv_ack  <= 1'b0;
         r_recv_data <= '0;
      end else begin
         r_recv_ack <= w_rx_pop;
         if (w_rx_pop) begin
            r_recv_data <= r_rxq[r_rx_rp];
            r_rx_rp     <= r_rx_rp + 3'd1;
         end
         if (w_rx_push) r_rx_wp <= r_rx_wp + 3'd1;
         unique case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 4'd1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 4'd1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   assign send_ack  = r_send_ack;
   assign recv_ack  = r_recv_ack;
   assign recv_data = r_recv_data;
   assign sendable  = ~w_tx_full;
   assign recvable  = ~w_rx_empty;
   assign Tx        = r_tx;

endmodule

// File: tb/tb_uart_comm.sv
// Directed bench for uart_comm at 16 clocks/bit with Tx->Rx loopback
// and a scoreboard queue of bytes expected at the host receive port.
module tb_uart_comm;

   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       send_flag;
   logic [7:0] send_data;
   logic       recv_flag;
   logic [7:0] recv_data;
   logic       send_ack, recv_ack, sendable, recvable;
   logic       Tx, Rx;
   logic       loop_en, drv_rx;

   int checks = 0;
   int failures = 0;
   int cyc_cnt = 0;
   logic [7:0] sb_q[$];

   assign Rx = loop_en ? Tx : drv_rx;

   uart_comm #(.ID(0), .BAUDRATE(1), .CLOCKRATE(DIV)) dut (
      .clk(clk), .rst(rst),
      .send_flag(send_flag), .send_data(send_data),
      .recv_flag(recv_flag), .recv_data(recv_data),
      .send_ack(send_ack), .recv_ack(recv_ack),
      .sendable(sendable), .recvable(recvable),
      .Tx(Tx), .Rx(Rx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit sb);
      int n = 0;
      send_flag = 1'b1;
      send_data = b;
      do begin
         cyc(1);
         n++;
      end while (!send_ack && n < 600);
      chk("send_ack", send_ack, 1);
      if (send_ack && sb) sb_q.push_back(b);
      send_flag = 1'b0;
      cyc(1);
      chk("send_ack_pulse", send_ack, 0);
   endtask

   task automatic recv_byte();
      int n = 0;
      logic [7:0] exp;
      recv_flag = 1'b1;
      do begin
         cyc(1);
         n++;
      end while (!recv_ack && n < 600);
      chk("recv_ack", recv_ack, 1);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
      chk("recv_data", recv_data, exp);
      recv_flag = 1'b0;
      cyc(1);
      chk("recv_ack_pulse", recv_ack, 0);
      chk("recv_data_hold", recv_data, exp);
   endtask

   task automatic check_frame(input logic [7:0] b);
      int n = 0;
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      while (Tx !== 1'b0 && n < 400) begin
         cyc(1);
         n++;
      end
      chk("tx_start_seen", Tx, 0);
      cyc(DIV / 2);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("tx_bit%0d", k), Tx, fr[k]);
         cyc(DIV);
      end
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stopb);
      drv_rx = 1'b0;
      cyc(DIV);
      for (int i = 0; i < 8; i++) begin
         drv_rx = b[i];
         cyc(DIV);
      end
      drv_rx = stopb;
      cyc(DIV);
      drv_rx = 1'b1;
      cyc(2 * DIV);
   endtask

   initial begin
      int n;
      int last_ack;
      int acks;
      logic [7:0] vals [4];
      logic [7:0] exp;
      vals[0] = 8'h81;
      vals[1] = 8'h00;
      vals[2] = 8'hFF;
      vals[3] = 8'h7E;

      rst = 1'b1;
      send_flag = 1'b0;
      send_data = 8'h00;
      recv_flag = 1'b0;
      loop_en = 1'b1;
      drv_rx = 1'b1;
      cyc(3);
      chk("rst_tx", Tx, 1);
      chk("rst_send_ack", send_ack, 0);
      chk("rst_recv_ack", recv_ack, 0);
      chk("rst_recv_data", recv_data, 0);
      chk("rst_sendable", sendable, 1);
      chk("rst_recvable", recvable, 0);
      rst = 1'b0;
      cyc(2);

      // single byte with frame shape and loopback
      send_byte(8'hA5, 1'b1);
      check_frame(8'hA5);
      recv_byte();
      chk("recvable_empty1", recvable, 0);

      // send_flag held across four bytes
      send_flag = 1'b1;
      send_data = vals[0];
      last_ack = -100;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            cyc(1);
            n++;
         end while (!send_ack && n < 600);
         chk("held_ack", send_ack, 1);
         chk("held_ack_gap", (cyc_cnt - last_ack) >= 2, 1);
         last_ack = cyc_cnt;
         if (send_ack) sb_q.push_back(vals[i]);
         if (i < 3) send_data = vals[i+1];
      end
      send_flag = 1'b0;
      recv_flag = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            cyc(1);
            n++;
         end while (!recv_ack && n < 800);
         chk("held_recv_ack", recv_ack, 1);
         exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
         chk("held_recv_data", recv_data, exp);
      end
      recv_flag = 1'b0;
      chk("recvable_drop", recvable, 0);
      cyc(2);

      // fill TX FIFO behind an in-flight byte; RX disconnected
      loop_en = 1'b0;
      send_byte(8'h01, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
      chk("full_sendable", sendable, 0);
      send_flag = 1'b1;
      send_data = 8'h99;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (send_ack) acks++;
      end
      chk("full_no_ack", acks, 0);
      n = 0;
      while (!send_ack && n < 400) begin
         cyc(1);
         n++;
      end
      chk("full_late_ack", send_ack, 1);
      send_flag = 1'b0;
      cyc(10 * 10 * DIV + 50);
      chk("drained_sendable", sendable, 1);
      chk("drained_tx_idle", Tx, 1);
      chk("no_rx_while_open", recvable, 0);

      // short low glitch on Rx
      drv_rx = 1'b0;
      cyc(3);
      drv_rx = 1'b1;
      cyc(20 * DIV);
      chk("glitch_recvable", recvable, 0);

      // framing error then a valid frame
      drive_frame(8'h55, 1'b0);
      chk("ferr_recvable", recvable, 0);
      sb_q.push_back(8'h3C);
      drive_frame(8'h3C, 1'b1);
      chk("valid_recvable", recvable, 1);
      recv_byte();

      // reset in mid-transmission
      loop_en = 1'b1;
      cyc(2);
      send_byte(8'h77, 1'b0);
      cyc(50);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", Tx, 1);
      chk("mid_rst_send_ack", send_ack, 0);
      chk("mid_rst_recv_ack", recv_ack, 0);
      chk("mid_rst_sendable", sendable, 1);
      chk("mid_rst_recvable", recvable, 0);
      cyc(2);
      rst = 1'b0;
      cyc(2);
      send_byte(8'h12, 1'b1);
      check_frame(8'h12);
      recv_byte();
      chk("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
